// File: rtl/bus_pkg.sv
// Shared types for the cmd/adr/data bus master: request record, FSM states, NOP code.
package bus_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;

  typedef struct packed {
    logic [3:0] cmd;
    logic [3:0] adr;
    logic [3:0] data;
    logic [3:0] len;
  } bus_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } bus_mst_state_e;

  // Beat field for beat i of a burst; wraps modulo 16 by construction.
  function automatic logic [3:0] beat_field(input logic [3:0] base, input logic [3:0] i);
    return base + i;
  endfunction

endpackage

// File: rtl/cmd_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module cmd_req_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  bus_req_t wdata,
  output logic     full,
  output logic     empty,
  output bus_req_t rdata
);

  localparam int AW = $clog2(DEPTH);

  bus_req_t       mem_r [DEPTH];
  logic [AW:0]    wr_ptr_r;
  logic [AW:0]    rd_ptr_r;
  logic           push_ok_s;
  logic           pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer and storage update; reset flushes every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/cmd_bus_master.sv
// Bus master: queues valid/ready requests and replays them as registered bursts with an idle gap.
module cmd_bus_master #(
  parameter int DEPTH = 4,
  parameter int GAP   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [3:0]       req_adr,
  input  logic [3:0]       req_data,
  input  logic [3:0]       req_len,
  output logic [3:0]       cmd,
  output logic [3:0]       adr,
  output logic [3:0]       data,
  output logic             busy,
  output logic [CNT_W-1:0] issued_count
);

  import bus_pkg::*;

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  bus_mst_state_e   state_r, state_s;
  bus_req_t         cur_r;
  bus_req_t         wdata_s;
  bus_req_t         rdata_s;
  logic [3:0]       beat_r, beat_s;
  logic [3:0]       gap_r, gap_s;
  logic [3:0]       cmd_r, adr_r, data_r;
  logic [3:0]       cmd_s, adr_s, data_s;
  logic [CNT_W-1:0] issued_r;
  logic             full_s, empty_s, push_s, pop_s, issue_s;

  assign wdata_s      = {req_cmd, req_adr, req_data, req_len};
  assign push_s       = req_valid && !full_s;
  assign req_ready    = !full_s;
  assign busy         = !empty_s || (state_r != IDLE);
  assign cmd          = cmd_r;
  assign adr          = adr_r;
  assign data         = data_r;
  assign issued_count = issued_r;

  cmd_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .full  (full_s),
    .empty (empty_s),
    .rdata (rdata_s)
  );

  // Next state, beat/gap counters and pop decision.
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    gap_s   = gap_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_s = DRIVE;
          beat_s  = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        if (beat_r == cur_r.len) begin
          if (GAP > 0) begin
            state_s = bus_pkg::GAP;
            gap_s   = GAP_LAST;
          end else if (!empty_s) begin
            pop_s  = 1'b1;
            beat_s = 4'd0;
          end else begin
            state_s = IDLE;
          end
        end else begin
          beat_s = beat_r + 4'd1;
        end
      end
      bus_pkg::GAP: begin
        if (gap_r == 4'd0) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_s = DRIVE;
            beat_s  = 4'd0;
          end else begin
            state_s = IDLE;
          end
        end else begin
          gap_s = gap_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bus beat for the current cycle; NOP beats and non-DRIVE states put 0/0/0 on the bus.
  always_comb begin
    issue_s = (state_r == DRIVE) && (cur_r.cmd != CMD_NOP);
    if (issue_s) begin
      cmd_s  = cur_r.cmd;
      adr_s  = beat_field(cur_r.adr, beat_r);
      data_s = beat_field(cur_r.data, beat_r);
    end else begin
      cmd_s  = 4'd0;
      adr_s  = 4'd0;
      data_s = 4'd0;
    end
  end

  // State, counters, current request and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cur_r    <= '0;
      beat_r   <= 4'd0;
      gap_r    <= 4'd0;
      cmd_r    <= 4'd0;
      adr_r    <= 4'd0;
      data_r   <= 4'd0;
      issued_r <= '0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      gap_r   <= gap_s;
      cmd_r   <= cmd_s;
      adr_r   <= adr_s;
      data_r  <= data_s;
      if (pop_s) begin
        cur_r <= rdata_s;
      end
      if (issue_s) begin
        issued_r <= issued_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cmd_bus_master.sv
// Directed bench for cmd_bus_master: one GAP=0 instance and one GAP=2 instance.
module tb_cmd_bus_master;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v0 = 1'b0, v1 = 1'b0;
  bus_req_t    req0 = '0, req1 = '0;
  logic        ready0, ready1, busy0, busy1;
  logic [3:0]  cmd0, adr0, data0, cmd1, adr1, data1;
  logic [15:0] iss0, iss1;

  int errors = 0;
  int checks = 0;

  logic [11:0] q[$];
  logic        mon_en = 1'b0;
  int          acc_edge[6];
  int          rel, guard, stale;

  always #5 clk = ~clk;

  cmd_bus_master #(.DEPTH(4), .GAP(0), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(ready0),
    .req_cmd(req0.cmd), .req_adr(req0.adr), .req_data(req0.data), .req_len(req0.len),
    .cmd(cmd0), .adr(adr0), .data(data0), .busy(busy0), .issued_count(iss0)
  );

  cmd_bus_master #(.DEPTH(4), .GAP(2), .CNT_W(16)) u_gap (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(ready1),
    .req_cmd(req1.cmd), .req_adr(req1.adr), .req_data(req1.data), .req_len(req1.len),
    .cmd(cmd1), .adr(adr1), .data(data1), .busy(busy1), .issued_count(iss1)
  );

  // Collect every non-NOP beat of the GAP=0 instance while enabled.
  always @(negedge clk) begin
    if (mon_en && cmd0 != 4'd0) q.push_back({cmd0, adr0, data0});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] adr_exp [4];
    logic [3:0] dat_exp [4];
    adr_exp = '{4'd14, 4'd15, 4'd0, 4'd1};
    dat_exp = '{4'd15, 4'd0, 4'd1, 4'd2};

    // Reset state of both instances
    step();
    step();
    chk("rst_bus0", {cmd0, adr0, data0}, 12'h000);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_ready0", ready0, 1'b1);
    chk("rst_iss0", iss0, 16'd0);
    chk("rst_bus1", {cmd1, adr1, data1}, 12'h000);
    chk("rst_ready1", ready1, 1'b1);
    rst = 1'b0;

    // Single beat: accepted at edge 1, on the bus after edge 3 only
    req0 = {4'd3, 4'd5, 4'd9, 4'd0};
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    chk("single_busy_e1", busy0, 1'b1);
    step();
    chk("single_bus_e2", {cmd0, adr0, data0}, 12'h000);
    step();
    chk("single_bus_e3", {cmd0, adr0, data0}, 12'h359);
    chk("single_iss_e3", iss0, 16'd1);
    chk("single_busy_e3", busy0, 1'b0);
    step();
    chk("single_bus_e4", {cmd0, adr0, data0}, 12'h000);
    chk("single_iss_e4", iss0, 16'd1);

    // Burst with address/data wrap
    do_reset();
    req0 = {4'd2, 4'd14, 4'd15, 4'd3};
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    step();
    for (int b = 0; b < 4; b++) begin
      step();
      chk("wrap_bus", {cmd0, adr0, data0}, {4'd2, adr_exp[b], dat_exp[b]});
      chk("wrap_iss", iss0, 16'(b + 1));
    end
    step();
    chk("wrap_bus_after", {cmd0, adr0, data0}, 12'h000);
    chk("wrap_busy_after", busy0, 1'b0);

    // Back-pressure: six 16-beat requests into a 4-deep FIFO
    do_reset();
    q.delete();
    mon_en = 1'b1;
    rel = 0;
    for (int i = 0; i < 6; i++) begin
      req0 = {4'(i + 1), 4'(i), 4'(i + 8), 4'd15};
      v0 = 1'b1;
      guard = 0;
      while (!ready0 && guard < 100) begin
        step();
        rel++;
        guard++;
      end
      if (guard >= 100) chk("bp_ready_timeout", guard, 0);
      step();
      rel++;
      acc_edge[i] = rel;
      if (i == 4) chk("bp_ready_low", ready0, 1'b0);
    end
    v0 = 1'b0;
    chk("bp_acc4_edge", acc_edge[3], 4);
    chk("bp_acc5_edge", acc_edge[4], 5);
    chk("bp_acc6_edge", acc_edge[5], 19);
    guard = 0;
    while (busy0 && guard < 300) begin
      step();
      guard++;
    end
    step();
    chk("bp_busy_done", busy0, 1'b0);
    mon_en = 1'b0;
    chk("bp_beats", q.size(), 96);
    if (q.size() == 96) begin
      for (int i = 0; i < 6; i++) begin
        for (int b = 0; b < 16; b++) begin
          chk("bp_beat", q[i * 16 + b], {4'(i + 1), 4'(i + b), 4'(i + 8 + b)});
        end
      end
    end
    chk("bp_iss", iss0, 16'd96);
    chk("bp_ready_end", ready0, 1'b1);

    // GAP=2 instance: two single beats separated by exactly two idle cycles
    do_reset();
    req1 = {4'd1, 4'd2, 4'd3, 4'd0};
    v1 = 1'b1;
    step();
    req1 = {4'd4, 4'd6, 4'd7, 4'd0};
    step();
    v1 = 1'b0;
    step();
    chk("gap_bus_e3", {cmd1, adr1, data1}, 12'h123);
    step();
    chk("gap_bus_e4", {cmd1, adr1, data1}, 12'h000);
    step();
    chk("gap_bus_e5", {cmd1, adr1, data1}, 12'h000);
    step();
    chk("gap_bus_e6", {cmd1, adr1, data1}, 12'h467);
    chk("gap_iss_e6", iss1, 16'd2);
    step();
    chk("gap_bus_e7", {cmd1, adr1, data1}, 12'h000);
    chk("gap_busy_e7", busy1, 1'b1);
    step();
    chk("gap_busy_e8", busy1, 1'b0);

    // NOP request between two cmd=7 beats
    do_reset();
    req0 = {4'd7, 4'd1, 4'd1, 4'd0};
    v0 = 1'b1;
    step();
    req0 = {4'd0, 4'd9, 4'd9, 4'd2};
    step();
    req0 = {4'd7, 4'd4, 4'd4, 4'd0};
    step();
    v0 = 1'b0;
    chk("nop_bus_e3", {cmd0, adr0, data0}, 12'h711);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("nop_idle", {cmd0, adr0, data0}, 12'h000);
    end
    step();
    chk("nop_bus_e7", {cmd0, adr0, data0}, 12'h744);
    chk("nop_iss", iss0, 16'd2);
    step();
    chk("nop_busy_e8", busy0, 1'b0);

    // Reset asserted during beat 2 of an 8-beat burst
    do_reset();
    req0 = {4'd5, 4'd0, 4'd0, 4'd7};
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_bus_beat2", {cmd0, adr0, data0}, 12'h522);
    chk("mid_iss_beat2", iss0, 16'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_bus", {cmd0, adr0, data0}, 12'h000);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_ready", ready0, 1'b1);
    chk("mid_rst_iss", iss0, 16'd0);
    step();
    rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if ({cmd0, adr0, data0} != 12'h000 || busy0) stale++;
    end
    chk("mid_no_stale", stale, 0);
    chk("mid_iss_after", iss0, 16'd0);
    chk("mid_ready_after", ready0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
